// File: rtl/memory_arbiter.sv
// Serialises instruction-fetch and data requests onto one single-ported RAM,
// returning registered ihit/dhit pulses with load data. Data wins unless it starves fetch.
module memory_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic          ihit,
    output logic          dhit,
    output logic [DW-1:0] iload,
    output logic [DW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic          ramrdy
);

    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IACC = 3'd1,
        DACC = 3'd2,
        IHIT = 3'd3,
        DHIT = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          ihit_q, ihit_d;
    logic          dhit_q, dhit_d;
    logic          ramren_q, ramren_d;
    logic          ramwen_q, ramwen_d;
    logic [AW-1:0] ramaddr_q, ramaddr_d;
    logic [DW-1:0] ramstore_q, ramstore_d;
    logic [DW-1:0] iload_q, iload_d;
    logic [DW-1:0] dload_q, dload_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          dwr_q, dwr_d;
    logic          dgrant;

    // Data goes first unless fetch is pending and data has already won MAX_DSTREAK times
    assign dgrant = (dREN | dWEN) & ((streak_q < SW'(MAX_DSTREAK)) | ~iREN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            iload_q    <= '0;
            dload_q    <= '0;
            streak_q   <= '0;
            dwr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ihit_q     <= ihit_d;
            dhit_q     <= dhit_d;
            ramren_q   <= ramren_d;
            ramwen_q   <= ramwen_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            streak_q   <= streak_d;
            dwr_q      <= dwr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dgrant)    state_d = DACC;
                else if (iREN) state_d = IACC;
            end
            IACC:       if (ramrdy) state_d = IHIT;
            DACC:       if (ramrdy) state_d = DHIT;
            IHIT, DHIT: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Registered outputs: strobes/latches set on grant, hit and load captured on ramrdy
    always_comb begin
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        ramren_d   = ramren_q;
        ramwen_d   = ramwen_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
        streak_d   = streak_q;
        dwr_d      = dwr_q;
        unique case (state_q)
            IDLE: begin
                if (dgrant) begin
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                    ramwen_d   = dWEN;
                    ramren_d   = ~dWEN;
                    dwr_d      = dWEN;
                    if (iREN && (streak_q != SW'(MAX_DSTREAK)))
                        streak_d = streak_q + SW'(1);
                end else if (iREN) begin
                    ramaddr_d = iaddr;
                    ramren_d  = 1'b1;
                    ramwen_d  = 1'b0;
                    streak_d  = '0;
                end
            end
            IACC: begin
                if (ramrdy) begin
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    iload_d  = ramload;
                    ihit_d   = 1'b1;
                end
            end
            DACC: begin
                if (ramrdy) begin
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    dhit_d   = 1'b1;
                    if (!dwr_q) dload_d = ramload;
                end
            end
            default: ;
        endcase
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign iload    = iload_q;
    assign dload    = dload_q;

endmodule
